// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the two-master Wishbone arbiter: FSM state encoding,
// master identifiers, the data word returned on a timeout abort, and a helper
// that turns the FSM state into the one-hot grant vector.
// Ports: none (package).
// -----------------------------------------------------------------------------
package wb_arb_pkg;

   // State codes double as the one-hot grant value of the owning master.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_OWN0 = 2'b01,
      ST_OWN1 = 2'b10
   } arb_state_t;

   localparam logic M0_ID = 1'b0;   // instruction fetch master (ibus)
   localparam logic M1_ID = 1'b1;   // load/store master (dbus)

   localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

   function automatic logic [1:0] state_to_grant(input arb_state_t st);
      logic [1:0] g;
      case (st)
         ST_OWN0: g = 2'b01;
         ST_OWN1: g = 2'b10;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/wb_master_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_master_arbiter_if
// Wishbone classic bus bundle used on both sides of the arbiter.
// Modports:
//   master : drives cyc/stb/we/addr/wdata/sel, receives rdata/ack/err
//   slave  : receives cyc/stb/we/addr/wdata/sel, drives rdata/ack/err
// The arbiter faces each CPU master with the slave modport and the bus
// decoder with the master modport.
// -----------------------------------------------------------------------------
interface wb_master_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SEL_W  = 4
);
   logic              cyc;
   logic              stb;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [SEL_W-1:0]  sel;
   logic [DATA_W-1:0] rdata;
   logic              ack;
   logic              err;

   modport master (
      output cyc, stb, we, addr, wdata, sel,
      input  rdata, ack, err
   );

   modport slave (
      input  cyc, stb, we, addr, wdata, sel,
      output rdata, ack, err
   );
endinterface

// File: rtl/wb_arb_timeout.sv
// -----------------------------------------------------------------------------
// wb_arb_timeout
// Stall counter for the arbiter's bus-ownership timeout. Only instantiated
// when WB_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-low reset
//   i_clr    in  clear the counter (held while the arbiter is idle)
//   i_en     in  count one owned cycle without slave acknowledge
//   o_expire out counter has reached TIMEOUT_CYC
// -----------------------------------------------------------------------------
module wb_arb_timeout
   import wb_arb_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);
   localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] r_cnt;

   assign o_expire = (r_cnt == CNT_W'(TIMEOUT_CYC));

   // Stall counter: saturates at the limit until the owner is released.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_expire) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule

// File: rtl/wb_master_arbiter.sv
// -----------------------------------------------------------------------------
// wb_master_arbiter
// Two-master round-robin Wishbone arbiter in front of the bus decoder.
// m0 = instruction fetch, m1 = load/store. The grant is taken in IDLE and held
// until the slave acknowledges, the owner drops cyc, or (optionally) the
// ownership timeout fires. Every grant is followed by one IDLE cycle.
// Optional feature: define WB_ARB_TIMEOUT_EN to abort a transfer after
// TIMEOUT_CYC owned cycles without ack (owner gets ack+err, rdata DEADBEEF).
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   m0, m1       if   CPU masters (slave modport of wb_master_arbiter_if)
//   s            if   shared port to the bus decoder (master modport)
//   grant        out  one-hot owner, 2'b00 when idle
//   timeout_flag out  sticky, set by any timeout since reset
// -----------------------------------------------------------------------------
module wb_master_arbiter
   import wb_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int SEL_W       = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rst,
   wb_master_arbiter_if.slave  m0,
   wb_master_arbiter_if.slave  m1,
   wb_master_arbiter_if.master s,
   output logic [1:0]          grant,
   output logic                timeout_flag
);
   arb_state_t        r_state;
   arb_state_t        w_next_state;
   logic              r_last;
   logic              w_next_last;
   logic              r_timeout_flag;
   logic              w_set_flag;
   logic              w_req0;
   logic              w_req1;
   logic              w_owner_id;
   logic              w_expire;

   logic              w_own_cyc;
   logic              w_own_stb;
   logic              w_own_we;
   logic [ADDR_W-1:0] w_own_addr;
   logic [DATA_W-1:0] w_own_wdata;
   logic [SEL_W-1:0]  w_own_sel;
   logic              w_own_ack;
   logic              w_own_err;
   logic [DATA_W-1:0] w_own_rdata;

   // The decoder never reports errors on this port.
   logic              w_unused_s_err;
   assign w_unused_s_err = s.err;

   assign w_req0       = m0.cyc & m0.stb;
   assign w_req1       = m1.cyc & m1.stb;
   assign w_owner_id   = (r_state == ST_OWN1) ? M1_ID : M0_ID;
   assign grant        = state_to_grant(r_state);
   assign timeout_flag = r_timeout_flag;

`ifdef WB_ARB_TIMEOUT_EN
   logic w_owned;
   logic w_cnt_clr;
   logic w_cnt_en;

   assign w_owned   = (r_state == ST_OWN0) || (r_state == ST_OWN1);
   assign w_cnt_clr = (r_state == ST_IDLE);
   assign w_cnt_en  = w_owned & ~s.ack;

   wb_arb_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_cnt_clr),
      .i_en     (w_cnt_en),
      .o_expire (w_expire)
   );
`else
   logic [31:0] w_unused_timeout_cyc;
   assign w_unused_timeout_cyc = 32'(TIMEOUT_CYC);
   assign w_expire             = 1'b0;
`endif

   // Owner view: the granted master's request signals, all zero when idle.
   always_comb begin
      w_own_cyc   = 1'b0;
      w_own_stb   = 1'b0;
      w_own_we    = 1'b0;
      w_own_addr  = '0;
      w_own_wdata = '0;
      w_own_sel   = '0;
      if (r_state == ST_OWN0) begin
         w_own_cyc   = m0.cyc;
         w_own_stb   = m0.stb;
         w_own_we    = m0.we;
         w_own_addr  = m0.addr;
         w_own_wdata = m0.wdata;
         w_own_sel   = m0.sel;
      end else if (r_state == ST_OWN1) begin
         w_own_cyc   = m1.cyc;
         w_own_stb   = m1.stb;
         w_own_we    = m1.we;
         w_own_addr  = m1.addr;
         w_own_wdata = m1.wdata;
         w_own_sel   = m1.sel;
      end else begin
         w_own_cyc   = 1'b0;
      end
   end

   // Next-state, round-robin pointer update and shared-port drive.
   always_comb begin
      w_next_state = r_state;
      w_next_last  = r_last;
      w_set_flag   = 1'b0;
      w_own_ack    = 1'b0;
      w_own_err    = 1'b0;
      w_own_rdata  = s.rdata;
      s.cyc        = 1'b0;
      s.stb        = 1'b0;
      s.we         = 1'b0;
      s.addr       = '0;
      s.wdata      = '0;
      s.sel        = '0;
      case (r_state)
         ST_IDLE: begin
            // A stray s_ack here is simply not forwarded.
            if (w_req0 && w_req1) begin
               w_next_state = (r_last == M1_ID) ? ST_OWN0 : ST_OWN1;
            end else if (w_req0) begin
               w_next_state = ST_OWN0;
            end else if (w_req1) begin
               w_next_state = ST_OWN1;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_OWN0, ST_OWN1: begin
            s.cyc   = w_own_cyc;
            s.stb   = w_own_stb;
            s.we    = w_own_we;
            s.addr  = w_own_addr;
            s.wdata = w_own_wdata;
            s.sel   = w_own_sel;
            if (!w_own_cyc) begin
               // Owner abandoned the cycle: release without any ack.
               w_next_state = ST_IDLE;
               w_next_last  = w_owner_id;
            end else if (s.ack) begin
               w_own_ack    = 1'b1;
               w_next_state = ST_IDLE;
               w_next_last  = w_owner_id;
            end else if (w_expire) begin
               // Cut the slave off and complete the owner with an error.
               s.cyc        = 1'b0;
               s.stb        = 1'b0;
               w_own_ack    = 1'b1;
               w_own_err    = 1'b1;
               w_own_rdata  = DATA_W'(ARB_ERR_DATA);
               w_set_flag   = 1'b1;
               w_next_state = ST_IDLE;
               w_next_last  = w_owner_id;
            end else begin
               w_next_state = r_state;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Return path: only the current owner sees ack, err and read data.
   always_comb begin
      m0.ack   = 1'b0;
      m0.err   = 1'b0;
      m0.rdata = '0;
      m1.ack   = 1'b0;
      m1.err   = 1'b0;
      m1.rdata = '0;
      if (r_state == ST_OWN0) begin
         m0.ack   = w_own_ack;
         m0.err   = w_own_err;
         m0.rdata = w_own_rdata;
      end else if (r_state == ST_OWN1) begin
         m1.ack   = w_own_ack;
         m1.err   = w_own_err;
         m1.rdata = w_own_rdata;
      end else begin
         m0.ack   = 1'b0;
      end
   end

   // State, round-robin pointer and sticky timeout flag registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= ST_IDLE;
         r_last         <= M1_ID;
         r_timeout_flag <= 1'b0;
      end else begin
         r_state        <= w_next_state;
         r_last         <= w_next_last;
         r_timeout_flag <= r_timeout_flag | w_set_flag;
      end
   end

endmodule

// File: tb/tb_wb_master_arbiter.sv
module tb_wb_master_arbiter;
   localparam int          TMO    = 8;
   localparam logic [31:0] RD_KEY = 32'hA5A5_0000;

   typedef struct {
      int          id;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  grant;
   logic        timeout_flag;

   int          n_vec = 0;
   int          n_miss = 0;
   exp_t        exp_q[$];
   logic [1:0]  g_seen[$];
   logic [1:0]  prev_grant;
   exp_t        mon_e;
   int          slv_delay = 1;
   int          slv_cnt;
   bit          slv_ack_en = 1'b1;

   wb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(4)) m0_if ();
   wb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(4)) m1_if ();
   wb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(4)) s_if ();

   wb_master_arbiter #(
      .ADDR_W(32), .DATA_W(32), .SEL_W(4), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst_n),
      .m0           (m0_if),
      .m1           (m1_if),
      .s            (s_if),
      .grant        (grant),
      .timeout_flag (timeout_flag)
   );

   always #5 clk = ~clk;

   // Slave model: ack slv_delay cycles after a strobe; read data keyed on address.
   assign s_if.err   = 1'b0;
   assign s_if.rdata = s_if.ack ? (s_if.addr ^ RD_KEY) : 32'h0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_if.ack <= 1'b0;
         slv_cnt  <= 0;
      end else if (s_if.cyc && s_if.stb && !s_if.ack && slv_ack_en) begin
         if (slv_cnt >= slv_delay - 1) begin
            s_if.ack <= 1'b1;
            slv_cnt  <= 0;
         end else begin
            slv_cnt  <= slv_cnt + 1;
         end
      end else begin
         s_if.ack <= 1'b0;
         if (!(s_if.cyc && s_if.stb)) slv_cnt <= 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every master ack, records each new grant.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_grant <= 2'b00;
      end else begin
         if (grant != 2'b00 && prev_grant == 2'b00) g_seen.push_back(grant);
         prev_grant <= grant;
         if (m0_if.ack || m1_if.ack) begin
            chk("dual_ack", {31'd0, m0_if.ack & m1_if.ack}, 32'd0);
            if (exp_q.size() == 0) begin
               chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("ack_master", m1_if.ack ? 32'd1 : 32'd0, 32'(mon_e.id));
               chk("ack_rdata", m1_if.ack ? m1_if.rdata : m0_if.rdata, mon_e.rdata);
               chk("ack_err", {31'd0, m1_if.ack ? m1_if.err : m0_if.err}, {31'd0, mon_e.err});
               chk("nonowner_rdata", m1_if.ack ? m0_if.rdata : m1_if.rdata, 32'd0);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int id, input logic cyc, input logic stb, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (id == 0) begin
         m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we;
         m0_if.addr = addr; m0_if.wdata = wdata; m0_if.sel = 4'hF;
      end else begin
         m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we;
         m1_if.addr = addr; m1_if.wdata = wdata; m1_if.sel = 4'h3;
      end
   endtask

   function automatic logic ack_of(input int id);
      return (id == 0) ? m0_if.ack : m1_if.ack;
   endfunction

   task automatic expect_ack(input int id, input logic [31:0] rdata, input logic err);
      exp_q.push_back('{id: id, rdata: rdata, err: err});
   endtask

   // Wait (bounded) for the master's ack, then let the ack edge pass.
   task automatic wait_ack(input int id);
      int n = 0;
      while (!ack_of(id) && n < 64) begin
         tick();
         n++;
      end
      chk($sformatf("ack_wait_m%0d", id), {31'd0, ack_of(id)}, 32'd1);
      tick();
   endtask

   task automatic m_xfer(input int id, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit drop);
      drive(id, 1'b1, 1'b1, we, addr, wdata);
      wait_ack(id);
      if (drop) drive(id, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic chk_grants(input string name, input int n, input logic [11:0] seq);
      chk({name, "_count"}, 32'(g_seen.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < g_seen.size())
            chk($sformatf("%s[%0d]", name, i), {30'd0, g_seen[i]}, {30'd0, seq[2*i +: 2]});
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #2;
      chk("rst_grant", {30'd0, grant}, 32'd0);
      chk("rst_s_cyc", {31'd0, s_if.cyc}, 32'd0);
      chk("rst_m0_ack", {31'd0, m0_if.ack}, 32'd0);
      chk("rst_m1_ack", {31'd0, m1_if.ack}, 32'd0);
      chk("rst_tflag", {31'd0, timeout_flag}, 32'd0);
      do_reset();
      tick();
      chk("idle_grant", {30'd0, grant}, 32'd0);

      // 1: single m0 read, slave acks one cycle after strobe
      expect_ack(0, 32'h0000_0100 ^ RD_KEY, 1'b0);
      drive(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
      tick();
      chk("t1_grant", {30'd0, grant}, 32'h1);
      chk("t1_s_cyc", {31'd0, s_if.cyc}, 32'd1);
      chk("t1_s_addr", s_if.addr, 32'h0000_0100);
      chk("t1_m0_ack_early", {31'd0, m0_if.ack}, 32'd0);
      tick();
      chk("t1_m0_ack", {31'd0, m0_if.ack}, 32'd1);
      chk("t1_m1_ack", {31'd0, m1_if.ack}, 32'd0);
      tick();
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t1_dead_grant", {30'd0, grant}, 32'd0);

      // 2: simultaneous requests after reset, then continuous alternation
      do_reset();
      g_seen.delete();
      expect_ack(0, 32'h200 ^ RD_KEY, 1'b0);
      expect_ack(1, 32'h300 ^ RD_KEY, 1'b0);
      fork
         m_xfer(0, 1'b0, 32'h200, 32'h0, 1'b1);
         m_xfer(1, 1'b0, 32'h300, 32'h0, 1'b1);
      join
      tick();
      expect_ack(0, 32'h204 ^ RD_KEY, 1'b0);
      expect_ack(1, 32'h304 ^ RD_KEY, 1'b0);
      expect_ack(0, 32'h208 ^ RD_KEY, 1'b0);
      expect_ack(1, 32'h308 ^ RD_KEY, 1'b0);
      fork
         begin
            m_xfer(0, 1'b0, 32'h204, 32'h0, 1'b0);
            m_xfer(0, 1'b0, 32'h208, 32'h0, 1'b1);
         end
         begin
            m_xfer(1, 1'b0, 32'h304, 32'h0, 1'b0);
            m_xfer(1, 1'b0, 32'h308, 32'h0, 1'b1);
         end
      join
      tick();
      chk_grants("t2_grants", 6, 12'b10_01_10_01_10_01);

      // 3: m1 write held off while m0 owns a stalled slave
      slv_delay = 5;
      expect_ack(0, 32'h400 ^ RD_KEY, 1'b0);
      expect_ack(1, 32'h500 ^ RD_KEY, 1'b0);
      drive(0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0);
      tick();
      drive(1, 1'b1, 1'b1, 1'b1, 32'h500, 32'h1234_5678);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t3_s_addr", s_if.addr, 32'h400);
         chk("t3_s_we", {31'd0, s_if.we}, 32'd0);
         chk("t3_grant", {30'd0, grant}, 32'h1);
         chk("t3_m1_ack", {31'd0, m1_if.ack}, 32'd0);
      end
      tick();
      chk("t3_m0_ack", {31'd0, m0_if.ack}, 32'd1);
      tick();
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t3_dead_grant", {30'd0, grant}, 32'd0);
      chk("t3_dead_s_cyc", {31'd0, s_if.cyc}, 32'd0);
      tick();
      chk("t3_m1_grant", {30'd0, grant}, 32'h2);
      chk("t3_m1_addr", s_if.addr, 32'h500);
      chk("t3_m1_we", {31'd0, s_if.we}, 32'd1);
      chk("t3_m1_wdata", s_if.wdata, 32'h1234_5678);
      chk("t3_m1_sel", {28'd0, s_if.sel}, 32'h3);
      wait_ack(1);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // 4: m0 abandons its cycle; the following tie goes to m1
      drive(0, 1'b1, 1'b1, 1'b0, 32'h600, 32'h0);
      tick();
      tick();
      chk("t4_s_cyc_on", {31'd0, s_if.cyc}, 32'd1);
      drive(0, 1'b0, 1'b1, 1'b0, 32'h600, 32'h0);
      #1;
      chk("t4_s_cyc_drop", {31'd0, s_if.cyc}, 32'd0);
      chk("t4_grant_held", {30'd0, grant}, 32'h1);
      tick();
      chk("t4_idle_grant", {30'd0, grant}, 32'd0);
      chk("t4_no_ack", {31'd0, m0_if.ack}, 32'd0);
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      slv_delay = 1;
      g_seen.delete();
      expect_ack(1, 32'h610 ^ RD_KEY, 1'b0);
      expect_ack(0, 32'h620 ^ RD_KEY, 1'b0);
      fork
         m_xfer(0, 1'b0, 32'h620, 32'h0, 1'b1);
         m_xfer(1, 1'b0, 32'h610, 32'h0, 1'b1);
      join
      tick();
      chk_grants("t4_grants", 2, {8'h00, 2'b01, 2'b10});

`ifdef WB_ARB_TIMEOUT_EN
      // 5: slave never acks; owner is completed with an error after TMO cycles
      slv_ack_en = 1'b0;
      expect_ack(1, 32'hDEAD_BEEF, 1'b1);
      drive(1, 1'b1, 1'b1, 1'b0, 32'h700, 32'h0);
      tick();
      for (int i = 0; i < TMO - 1; i++) begin
         tick();
         chk("t5_no_ack", {31'd0, m1_if.ack}, 32'd0);
      end
      tick();
      chk("t5_ack", {31'd0, m1_if.ack}, 32'd1);
      chk("t5_err", {31'd0, m1_if.err}, 32'd1);
      chk("t5_s_cyc", {31'd0, s_if.cyc}, 32'd0);
      tick();
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t5_tflag", {31'd0, timeout_flag}, 32'd1);
      tick();
      tick();
      chk("t5_tflag_sticky", {31'd0, timeout_flag}, 32'd1);
      slv_ack_en = 1'b1;
`else
      chk("no_tflag", {31'd0, timeout_flag}, 32'd0);
`endif

      // 6: asynchronous reset while m1 owns the bus
      slv_delay = 5;
      drive(1, 1'b1, 1'b1, 1'b0, 32'h800, 32'h0);
      tick();
      chk("t6_grant", {30'd0, grant}, 32'h2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_grant", {30'd0, grant}, 32'd0);
      chk("t6_rst_s_cyc", {31'd0, s_if.cyc}, 32'd0);
      chk("t6_rst_m1_ack", {31'd0, m1_if.ack}, 32'd0);
      chk("t6_rst_tflag", {31'd0, timeout_flag}, 32'd0);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      rst_n = 1'b1;
      slv_delay = 1;
      tick();
      g_seen.delete();
      expect_ack(0, 32'h900 ^ RD_KEY, 1'b0);
      expect_ack(1, 32'h910 ^ RD_KEY, 1'b0);
      fork
         m_xfer(0, 1'b0, 32'h900, 32'h0, 1'b1);
         m_xfer(1, 1'b0, 32'h910, 32'h0, 1'b1);
      join
      tick();
      chk_grants("t6_grants", 2, {8'h00, 2'b10, 2'b01});

      tick();
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
